// File: rtl/uart_tx_fifo_drain.sv
// Purpose: UART transmitter that pops words from a first-word-fall-through FIFO and sends them as serial frames.
// Latency: the pop strobe is combinational; tx/busy follow on the next edge; back-to-back pops are one frame apart.
// Backpressure: the upstream empty flag throttles pops; a pop happens only from IDLE or the final stop-bit cycle.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset   - synchronous, active-high reset
//   empty   - FIFO empty flag
//   r_data  - FIFO head word, valid whenever empty=0
//   r_en    - FIFO pop strobe, single-cycle pulse
//   tx      - serial line, idle high (registered)
//   busy    - high while a frame is in progress (registered)
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after the data bits.

module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state_q, state_n;
    logic [BAUD_W-1:0]     baud_q, baud_n;
    logic [BIT_W-1:0]      bit_q, bit_n;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
    logic                  tx_n;
    logic                  busy_n;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the word at pop time, since the shift register
    // has been shifted out by the time the parity bit is sent.
    logic parity_q, parity_n;
`endif

    logic bit_end;
    logic data_last;
    logic stop_end;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign data_last = (state_q == S_DATA) && bit_end && (bit_q == DATA_LAST);
    // The bit counter also counts stop bits, so one comparison covers 1 or 2 stop bits.
    assign stop_end  = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);

    // Pop from IDLE, or in the very last stop cycle so the next start bit
    // follows with no idle gap.
    assign r_en = !reset && !empty && ((state_q == S_IDLE) || stop_end);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (r_en) state_n = S_START;
            end
            S_START: begin
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                if (data_last) begin
`ifdef UART_TX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (stop_end) state_n = r_en ? S_START : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Counters and shift register
    always_comb begin
        baud_n  = baud_q;
        bit_n   = bit_q;
        shreg_n = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_n = parity_q;
`endif
        if (r_en) begin
            baud_n  = '0;
            bit_n   = '0;
            shreg_n = r_data;
`ifdef UART_TX_PARITY_EN
            parity_n = ^r_data;
`endif
        end else if (state_q != S_IDLE) begin
            baud_n = bit_end ? '0 : baud_q + 1'b1;
            if ((state_q == S_DATA) && bit_end) begin
                shreg_n = shreg_q >> 1;
                bit_n   = data_last ? '0 : bit_q + 1'b1;
            end
            if ((state_q == S_STOP) && bit_end) begin
                bit_n = stop_end ? '0 : bit_q + 1'b1;
            end
        end
    end

    // Outputs are registered, so derive their next values from the next state.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = parity_q;
`endif
            default:  tx_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shreg_q <= shreg_n;
            tx      <= tx_n;
            busy    <= busy_n;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

UART transmitter that drains the transmit FIFO. It sits directly downstream of the FIFO pointer controller and its storage. When the FIFO is non-empty it pops one word and serialises it as an asynchronous frame on `tx`: start bit, data LSB first, optional even parity, then stop bit(s). When the frame ends it pops the next word back-to-back, with no idle gap.

## Interface
- `DATA_WIDTH`, 8, bits per frame and FIFO word width
- `CLKS_PER_BIT`, 16, clk cycles per serial bit; legal range ≥ 2
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `empty`  in  1  FIFO empty flag
- `r_data`  in  DATA_WIDTH  FIFO head word; valid combinationally whenever `empty`=0 (first-word fall-through)
- `r_en`  out  1  FIFO pop strobe; single-cycle pulse
- `tx`  out  1  serial line; idle high
- `busy`  out  1  high whenever a frame is in progress

## Operation
- FSM states and sequence: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
- `r_en` is combinational. It is asserted only when `empty`=0, in either of two cycles:
  - the state is IDLE; or
  - the state is STOP and this is the final clk cycle of the last stop bit.
- `r_en` is never asserted while `empty`=1 or during `reset`.
- In the same cycle `r_en` is high, `r_data` is latched into the shift register, the baud counter clears, and the FSM moves to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: shift register LSB is driven on `tx`. The register shifts right once per bit period. The bit counter runs 0..DATA_WIDTH-1 and the FSM leaves DATA after bit DATA_WIDTH-1.
- PARITY (only with the macro enabled): `tx` = XOR of all latched data bits (even parity) for one bit period.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - At the end of STOP, go to START if `empty`=0 (pop as above).
  - Otherwise go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit counter: width $clog2(DATA_WIDTH)+1. It is used for DATA, and reused for stop bits when STOP_BITS=2.
- `busy` = (state != IDLE).

## Timing
- Reset values: state=IDLE, `tx`=1, `busy`=0, `r_en`=0, both counters 0, shift register 0.
- `tx` and `busy` are registered.
- Start latency: `empty` falls while IDLE in cycle N. Then `r_en`=1 in cycle N, and `tx`=0 and `busy`=1 from cycle N+1.
- Frame length: F = (1 + DATA_WIDTH + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- Back-to-back frames: consecutive `r_en` pulses are exactly F cycles apart, and `tx` never shows an extra idle cycle between frames.
- Isolated frame: the earliest next pop from IDLE is the cycle after the FSM returns to IDLE.
- `empty` falling during a frame has no effect until the final STOP cycle.
- `r_data` changing mid-frame has no effect, because the data is latched at pop.
- Reset mid-frame:
  - the frame is aborted and no pop occurs in the reset cycle;
  - `tx`=1 and `busy`=0 on the next edge;
  - the word already popped is lost. This is accepted behaviour.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state and even-parity bit are compiled in;
  - F includes one extra bit period (P=1).
- Undefined:
  - no PARITY state exists, and DATA goes directly to STOP;
  - P=0.

## Test plan
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1, no parity; FIFO holds 0xA5 → exactly one `r_en` pulse. `tx` per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. `busy` high for 40 cycles, then `tx`=1 and `busy`=0.
- Back-to-back, FIFO holds 0x00 then 0xFF, no parity → two `r_en` pulses exactly 40 cycles apart. The second frame's start bit immediately follows the first frame's stop bit. `busy` stays high for 80 cycles.
- Parity with `UART_TX_PARITY_EN` → 0x01 yields parity bit 1 and 0xA5 yields parity bit 0. F=44 cycles at CLKS_PER_BIT=4.
- STOP_BITS=2, CLKS_PER_BIT=4, 0x3C → the stop high period is 8 cycles and F=44 (no parity). The next `r_en` occurs in the last cycle of the second stop bit.
- `empty` held at 1 for 200 cycles after reset → `r_en` never asserted, `tx`=1 and `busy`=0 throughout.
- Reset asserted in cycle 10 of a 0x5A frame with the FIFO still non-empty → no `r_en` in the reset cycle, `tx`=1 and `busy`=0 on the next edge. A new frame starts one cycle after `reset` deasserts.
